// File: rtl/occamy_pkg.sv
// occamy_pkg: regbus request/response types shared by the SoC interconnect
package occamy_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;
endpackage

// File: rtl/occamy_regbus_rr_pick.sv
// occamy_regbus_rr_pick: first set bit of valid at or after ptr, wrapping
module occamy_regbus_rr_pick #(
  parameter int NumReq = 4,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic              found,
  output logic [IdxW-1:0]   idx
);
  logic [IdxW-1:0] j;
  // scanned farthest-first so the candidate closest to ptr is written last
  always_comb begin
    idx = '0;
    j = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = IdxW'((int'(ptr) + i) % NumReq);
      if (valid[j]) idx = j;
    end
  end
  assign found = |valid;
endmodule

// File: rtl/occamy_regbus_arbiter.sv
// occamy_regbus_arbiter: round-robin share of one regbus target with timeout abort
module occamy_regbus_arbiter
  import occamy_pkg::*;
#(
  parameter int NumReq = 4,
  parameter int TimeoutCycles = 256,
  parameter type req_t = reg_a48_d32_req_t,
  parameter type rsp_t = reg_a48_d32_rsp_t,
  localparam int IdxW = $clog2(NumReq)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  req_t            req_i [NumReq],
  output rsp_t            rsp_o [NumReq],
  output req_t            req_o,
  input  rsp_t            rsp_i,
  output logic            busy_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            timeout_o
);
  localparam int CntW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  typedef enum logic {IDLE, BUSY} state_e;
  state_e            state, state_d;
  logic [IdxW-1:0]   ptr, ptr_d, gnt, gnt_d, pick_idx;
  logic [CntW-1:0]   cnt, cnt_d;
  logic [NumReq-1:0] valid;
  logic              found, done, abort;
  always_comb
    for (int k = 0; k < NumReq; k++) valid[k] = req_i[k].valid;
  occamy_regbus_rr_pick #(.NumReq(NumReq)) u_pick (
    .valid(valid),
    .ptr  (ptr),
    .found(found),
    .idx  (pick_idx)
  );
  // a target answer in the last allowed cycle beats the abort
  assign done  = state == BUSY && rsp_i.ready;
  assign abort = TimeoutCycles > 0 && state == BUSY && !rsp_i.ready &&
                 cnt == CntW'(TimeoutCycles - 1);
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    gnt_d = gnt;
    cnt_d = cnt;
    if (state == IDLE) begin
      if (found) begin
        state_d = BUSY;
        gnt_d = pick_idx;
      end
    end else if (done || abort) begin
      state_d = IDLE;
      ptr_d = gnt == IdxW'(NumReq - 1) ? '0 : gnt + 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt + 1'b1;
    end
  end
  always_comb begin
    req_o = '0;
    if (state == BUSY) begin
      req_o = req_i[gnt];
      if (abort) req_o.valid = 1'b0;
    end
    for (int k = 0; k < NumReq; k++) rsp_o[k] = '0;
    if (done) begin
      rsp_o[gnt] = rsp_i;
    end else if (abort) begin
      rsp_o[gnt].error = 1'b1;
      rsp_o[gnt].ready = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
      cnt <= '0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      gnt <= gnt_d;
      cnt <= cnt_d;
    end
  assign busy_o = state == BUSY;
  assign gnt_idx_o = gnt;
  assign timeout_o = abort;
endmodule

// File: tb/tb_occamy_regbus_arbiter.sv
// tb_occamy_regbus_arbiter: directed vector table plus timeout and reset sequences
module tb_occamy_regbus_arbiter;
  import occamy_pkg::*;
  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [31:0] rdata;
    logic        busy;
    logic [1:0]  gnt;
    logic [3:0]  mask;
    logic        err;
    logic        to;
    logic        reqv;
  } vec_t;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  reg_a48_d32_req_t req_i [4];
  reg_a48_d32_req_t pl [4];
  reg_a48_d32_req_t req_o;
  reg_a48_d32_rsp_t rsp_o [4];
  reg_a48_d32_rsp_t rsp_i;
  logic       busy_o, timeout_o;
  logic [1:0] gnt_idx_o;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  occamy_regbus_arbiter #(.NumReq(4), .TimeoutCycles(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .rsp_o    (rsp_o),
    .req_o    (req_o),
    .rsp_i    (rsp_i),
    .busy_o   (busy_o),
    .gnt_idx_o(gnt_idx_o),
    .timeout_o(timeout_o)
  );
  function automatic vec_t mk(logic [3:0] v, logic rdy, logic [31:0] rdata, logic busy,
                              logic [1:0] gnt, logic [3:0] mask, logic err, logic to, logic reqv);
    vec_t t;
    t.v = v; t.rdy = rdy; t.rdata = rdata; t.busy = busy; t.gnt = gnt;
    t.mask = mask; t.err = err; t.to = to; t.reqv = reqv;
    return t;
  endfunction
  task automatic drive(vec_t t);
    for (int k = 0; k < 4; k++) begin
      req_i[k] = pl[k];
      req_i[k].valid = t.v[k];
    end
    rsp_i = reg_a48_d32_rsp_t'{t.rdata, 1'b0, t.rdy};
  endtask
  task automatic check(string tag, vec_t t);
    reg_a48_d32_req_t er;
    reg_a48_d32_rsp_t ers [4];
    logic ok;
    er = '0;
    if (t.busy) begin
      er = pl[t.gnt];
      er.valid = t.reqv;
    end
    for (int k = 0; k < 4; k++)
      ers[k] = !t.mask[k] ? reg_a48_d32_rsp_t'('0) :
               t.err ? reg_a48_d32_rsp_t'{32'h0, 1'b1, 1'b1} :
                       reg_a48_d32_rsp_t'{t.rdata, 1'b0, 1'b1};
    ok = busy_o === t.busy && gnt_idx_o === t.gnt && timeout_o === t.to &&
         (t.to ? req_o.valid === 1'b0 : req_o === er);
    for (int k = 0; k < 4; k++) ok = ok && rsp_o[k] === ers[k];
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got busy=%b gnt=%0d to=%b req_o=%h rsp_o=%h/%h/%h/%h, want busy=%b gnt=%0d to=%b req_o=%h rsp_o=%h/%h/%h/%h",
               tag, busy_o, gnt_idx_o, timeout_o, req_o, rsp_o[0], rsp_o[1], rsp_o[2], rsp_o[3],
               t.busy, t.gnt, t.to, er, ers[0], ers[1], ers[2], ers[3]);
    end
  endtask
  task automatic apply(string tag, vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    check(tag, t);
  endtask
  task automatic do_reset();
    @(negedge clk);
    drive(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask
  initial begin
    pl[0] = '{48'h0000_0000_1000, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    pl[1] = '{48'h0000_0200_0004, 1'b1, 32'h1234_5678, 4'hF, 1'b0};
    pl[2] = '{48'h0000_0100_0000, 1'b0, 32'h0000_0000, 4'h0, 1'b0};
    pl[3] = '{48'h0000_0300_00F0, 1'b1, 32'hA5A5_5A5A, 4'h3, 1'b0};
    // round robin with everyone requesting and a zero-wait target
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0000, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0001, 1, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0002, 0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0003, 1, 1, 4'h2, 0, 0, 1));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0004, 0, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0005, 1, 2, 4'h4, 0, 0, 1));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0006, 0, 2, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0007, 1, 3, 4'h8, 0, 0, 1));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0008, 0, 3, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h1111_0009, 1, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    // single read from requester 2
    tbl.push_back(mk(4'h4, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h4, 1, 32'hDEAD_BEEF, 1, 2, 4'h4, 0, 0, 1));
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 2, 4'h0, 0, 0, 0));
    // pointer skips idle requesters
    tbl.push_back(mk(4'h5, 0, 32'h0,         0, 2, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h5, 1, 32'h2222_0000, 1, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(4'h5, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h5, 1, 32'h2222_0002, 1, 2, 4'h4, 0, 0, 1));
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 2, 4'h0, 0, 0, 0));
    // write from requester 1 with wait states; requester 0 arrives while busy
    tbl.push_back(mk(4'h2, 0, 32'h0,         0, 2, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h3, 0, 32'h0,         1, 1, 4'h0, 0, 0, 1));
    tbl.push_back(mk(4'h3, 0, 32'h0,         1, 1, 4'h0, 0, 0, 1));
    tbl.push_back(mk(4'h3, 1, 32'h0000_0001, 1, 1, 4'h2, 0, 0, 1));
    tbl.push_back(mk(4'h1, 0, 32'h0,         0, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h1, 1, 32'h3333_0000, 1, 0, 4'h1, 0, 0, 1));
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    // grantee drops valid mid-transaction
    tbl.push_back(mk(4'h2, 0, 32'h0,         0, 0, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 0, 32'h0,         1, 1, 4'h0, 0, 0, 0));
    tbl.push_back(mk(4'h2, 1, 32'h4444_0001, 1, 1, 4'h2, 0, 0, 1));
    tbl.push_back(mk(4'h0, 0, 32'h0,         0, 1, 4'h0, 0, 0, 0));
    // held in reset with live traffic: everything must stay quiet
    drive(mk(4'hF, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #1;
    check("reset", mk(4'hF, 1, 32'hDEAD_BEEF, 0, 0, 4'h0, 0, 0, 0));
    @(negedge clk);
    drive(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_ni = 1'b1;
    foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);
    // timeout: target silent for 8 busy cycles, then pointer moves on
    do_reset();
    apply("to_idle", mk(4'h3, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    for (int i = 0; i < 7; i++) apply($sformatf("to_wait%0d", i), mk(4'h3, 0, 0, 1, 0, 4'h0, 0, 0, 1));
    apply("to_abort", mk(4'h3, 0, 32'hFFFF_FFFF, 1, 0, 4'h1, 1, 1, 0));
    apply("to_idle2", mk(4'h3, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    apply("to_next_g1", mk(4'h3, 1, 32'h5555_0001, 1, 1, 4'h2, 0, 0, 1));
    apply("to_quiet", mk(4'h0, 0, 0, 0, 1, 4'h0, 0, 0, 0));
    // ready on the last allowed cycle wins, and the counter restarts afterwards
    do_reset();
    apply("late_idle", mk(4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    for (int i = 0; i < 7; i++) apply($sformatf("late_wait%0d", i), mk(4'h1, 0, 0, 1, 0, 4'h0, 0, 0, 1));
    apply("late_ready", mk(4'h1, 1, 32'hCAFE_0008, 1, 0, 4'h1, 0, 0, 1));
    apply("late_idle2", mk(4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    for (int i = 0; i < 7; i++) apply($sformatf("late2_wait%0d", i), mk(4'h1, 0, 0, 1, 0, 4'h0, 0, 0, 1));
    apply("late2_abort", mk(4'h1, 0, 0, 1, 0, 4'h1, 1, 1, 0));
    apply("late2_quiet", mk(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    // asynchronous reset in the middle of a wait
    do_reset();
    apply("rst_idle", mk(4'h1, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    apply("rst_g0", mk(4'h1, 1, 32'h0BAD_F00D, 1, 0, 4'h1, 0, 0, 1));
    apply("rst_pick", mk(4'h5, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    apply("rst_busy0", mk(4'h5, 0, 0, 1, 2, 4'h0, 0, 0, 1));
    apply("rst_busy1", mk(4'h5, 0, 0, 1, 2, 4'h0, 0, 0, 1));
    rst_ni = 1'b0;
    #1;
    check("rst_async", mk(4'h5, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    @(negedge clk);
    drive(mk(4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_ni = 1'b1;
    apply("rst_rel_idle", mk(4'h5, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    apply("rst_rel_g0", mk(4'h5, 1, 32'h7777_0000, 1, 0, 4'h1, 0, 0, 1));
    apply("rst_rel_quiet", mk(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
